// File: rtl/spi_puzzle_responder.sv
// rtl/spi_puzzle_responder.sv - SPI mode-0 slave streaming puzzle bytes out on MISO and collecting result bytes from MOSI
module spi_puzzle_responder #(
  parameter int         SYNC_FLOPS   = 2,
  parameter int         RESULT_BYTES = 2,
  parameter logic [7:0] FILL_BYTE    = 8'h00
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      spi_sclk,
  input  logic                      spi_mosi,
  input  logic                      spi_ss_n,
  output logic                      spi_miso,
  output logic                      spi_miso_oe,
  input  logic [7:0]                tx_data,
  input  logic                      tx_last,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  output logic [RESULT_BYTES*8-1:0] result_out,
  output logic                      result_valid,
  output logic                      test_complete,
  output logic                      underrun
);

  localparam int RW = RESULT_BYTES * 8;
  localparam int CW = $clog2(RESULT_BYTES + 1);
  localparam logic [CW-1:0] RES_MAX  = CW'(RESULT_BYTES);
  localparam logic [CW-1:0] RES_LAST = CW'(RESULT_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  logic [SYNC_FLOPS-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                  sclk_d, ss_d;
  logic                  sclk_s, mosi_s, ss_s;
  logic                  sclk_rise, sclk_fall, ss_fall, ss_rise;

  state_t          state;
  logic [2:0]      bit_cnt;
  logic [7:0]      tx_shift;
  logic [7:0]      rx_shift;
  logic            byte_done;
  logic            last_lat;
  logic            stream_done;
  logic [CW-1:0]   res_cnt;

  // Sync chains idle at the bus rest levels so reset never looks like an SS fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_FLOPS-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_FLOPS-2:0], spi_mosi};
      ss_sync   <= {ss_sync[SYNC_FLOPS-2:0], spi_ss_n};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_FLOPS-1];
  assign mosi_s    = mosi_sync[SYNC_FLOPS-1];
  assign ss_s      = ss_sync[SYNC_FLOPS-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      bit_cnt       <= 3'd0;
      tx_shift      <= 8'h00;
      rx_shift      <= 8'h00;
      byte_done     <= 1'b0;
      last_lat      <= 1'b0;
      stream_done   <= 1'b0;
      res_cnt       <= '0;
      spi_miso      <= 1'b0;
      spi_miso_oe   <= 1'b0;
      tx_ready      <= 1'b0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      result_out    <= '0;
      result_valid  <= 1'b0;
      test_complete <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      result_valid <= 1'b0;
      tx_ready     <= 1'b0;
      byte_done    <= 1'b0;

      // Completed bytes are published one cycle after the 8th rising edge.
      if (byte_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        if (stream_done && res_cnt != RES_MAX) begin
          result_out <= (result_out << 8) | RW'(rx_shift);
          res_cnt    <= res_cnt + CW'(1);
          if (res_cnt == RES_LAST) begin
            result_valid  <= 1'b1;
            test_complete <= 1'b1;
          end
        end
      end

      if (ss_rise) begin
        state       <= S_IDLE;
        spi_miso_oe <= 1'b0;
        bit_cnt     <= 3'd0;
        byte_done   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
            bit_cnt     <= 3'd0;
            last_lat    <= 1'b0;
            if (ss_fall) begin
              state    <= S_LOAD;
              tx_ready <= ~stream_done;
            end
          end

          S_LOAD: begin
            spi_miso_oe <= 1'b1;
            if (stream_done) begin
              tx_shift <= FILL_BYTE;
              last_lat <= 1'b0;
            end else if (tx_valid) begin
              tx_shift <= tx_data;
              last_lat <= tx_last;
            end else begin
              tx_shift <= FILL_BYTE;
              last_lat <= 1'b0;
              underrun <= 1'b1;
            end
            state <= S_SHIFT;
          end

          S_SHIFT: begin
            spi_miso <= tx_shift[7];
            if (sclk_rise) begin
              rx_shift <= {rx_shift[6:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end else if (sclk_fall) begin
              if (bit_cnt != 3'd0) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
              end else begin
                // Byte boundary: a finished last byte ends the stream before the next load.
                stream_done <= stream_done | last_lat;
                tx_ready    <= ~(stream_done | last_lat);
                state       <= S_LOAD;
              end
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_puzzle_responder.sv
// tb/tb_spi_puzzle_responder.sv - directed bench for spi_puzzle_responder driving a mode-0 SPI master
module tb_spi_puzzle_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_ss_n = 1'b1;
  logic        spi_miso, spi_miso_oe;
  logic [7:0]  tx_data;
  logic        tx_last, tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] result_out;
  logic        result_valid, test_complete, underrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_mem [0:15];
  logic       tx_last_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int rx_cnt = 0;
  int rv_cnt = 0;

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] exp_miso;
  } vec_t;
  vec_t tbl [0:4];

  spi_puzzle_responder #(.SYNC_FLOPS(2), .RESULT_BYTES(2), .FILL_BYTE(8'h00)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .result_out(result_out), .result_valid(result_valid),
    .test_complete(test_complete), .underrun(underrun)
  );

  always #5 clk = ~clk;

  assign tx_valid = (rd_ptr != wr_ptr);
  assign tx_data  = tx_mem[rd_ptr[3:0]];
  assign tx_last  = tx_last_mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
    if (rx_valid) rx_cnt <= rx_cnt + 1;
    if (result_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic last);
    tx_mem[wr_ptr[3:0]]      = d;
    tx_last_mem[wr_ptr[3:0]] = last;
    wr_ptr++;
  endtask

  task automatic do_reset();
    reset = 1'b1; spi_ss_n = 1'b1; spi_sclk = 1'b0;
    repeat (3) wait_clk();
    reset = 1'b0;
    repeat (2) wait_clk();
  endtask

  task automatic start_frame();
    spi_ss_n = 1'b0;
    repeat (5) wait_clk();
  endtask

  task automatic end_frame();
    repeat (6) wait_clk();
    spi_ss_n = 1'b1;
    repeat (8) wait_clk();
  endtask

  // Master samples MISO just before each rising edge; returns right after the last falling edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      repeat (6) wait_clk();
      mi = {mi[6:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (6) wait_clk();
      spi_sclk = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int p0, r0, v0;

    tbl[0] = '{8'h00, 8'hA5};
    tbl[1] = '{8'h00, 8'h3C};
    tbl[2] = '{8'h42, 8'h00};
    tbl[3] = '{8'h61, 8'h00};
    tbl[4] = '{8'h99, 8'h00};

    // Reset with SS low and SCLK toggling.
    reset = 1'b1; spi_ss_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      spi_sclk = ~spi_sclk;
      wait_clk();
    end
    check("reset_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("reset_miso", {31'd0, spi_miso}, 32'd0);
    check("reset_flags", {28'd0, tx_ready, rx_valid, test_complete, underrun}, 32'd0);
    check("reset_result", {16'd0, result_out}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    spi_ss_n = 1'b1; spi_sclk = 1'b0;
    wait_clk();
    reset = 1'b0;
    repeat (3) wait_clk();

    // Underrun then recovery inside one frame.
    p0 = pop_cnt;
    start_frame();
    check("frame_oe", {31'd0, spi_miso_oe}, 32'd1);
    xfer(8'h00, 8, got);
    check("underrun_miso", {24'd0, got}, 32'h00);
    check("underrun_flag", {31'd0, underrun}, 32'd1);
    check("underrun_no_pop", pop_cnt - p0, 32'd0);
    push(8'h5A, 1'b0);
    xfer(8'h00, 8, got);
    check("recover_miso", {24'd0, got}, 32'h5A);
    check("recover_pop", pop_cnt - p0, 32'd1);
    end_frame();
    check("idle_oe", {31'd0, spi_miso_oe}, 32'd0);

    // Abort after three bits of 8'hF0.
    push(8'hF0, 1'b0);
    push(8'h77, 1'b0);
    r0 = rx_cnt;
    start_frame();
    xfer(8'h00, 3, got);
    check("abort_bits", {24'd0, got}, 32'h07);
    spi_ss_n = 1'b1;
    repeat (4) wait_clk();
    check("abort_oe", {31'd0, spi_miso_oe}, 32'd0);
    repeat (8) wait_clk();
    check("abort_no_rx", rx_cnt - r0, 32'd0);
    start_frame();
    xfer(8'h00, 8, got);
    check("after_abort_miso", {24'd0, got}, 32'h77);
    end_frame();

    // Stream then result bytes, table-driven.
    do_reset();
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b1);
    p0 = pop_cnt; r0 = rx_cnt; v0 = rv_cnt;
    start_frame();
    for (int i = 0; i < 5; i++) begin
      xfer(tbl[i].mosi, 8, got);
      check($sformatf("tbl_miso_%0d", i), {24'd0, got}, {24'd0, tbl[i].exp_miso});
      check($sformatf("tbl_rx_%0d", i), {24'd0, rx_data}, {24'd0, tbl[i].mosi});
    end
    end_frame();
    check("stream_pops", pop_cnt - p0, 32'd2);
    check("stream_underrun", {31'd0, underrun}, 32'd0);
    check("rx_count", rx_cnt - r0, 32'd5);
    check("result_pulses", rv_cnt - v0, 32'd1);
    check("result_out", {16'd0, result_out}, 32'h4261);
    check("test_complete", {31'd0, test_complete}, 32'd1);

    // Reset during the second result byte.
    do_reset();
    push(8'h11, 1'b1);
    start_frame();
    xfer(8'h00, 8, got);
    check("r6_stream_miso", {24'd0, got}, 32'h11);
    xfer(8'h42, 8, got);
    repeat (4) wait_clk();
    check("r6_partial_result", {16'd0, result_out}, 32'h0042);
    xfer(8'h61, 3, got);
    reset = 1'b1; spi_ss_n = 1'b1; spi_sclk = 1'b0;
    repeat (2) wait_clk();
    check("r6_result_cleared", {16'd0, result_out}, 32'h0000);
    check("r6_tc_cleared", {31'd0, test_complete}, 32'd0);
    reset = 1'b0;
    repeat (2) wait_clk();
    push(8'h22, 1'b0);
    p0 = pop_cnt;
    start_frame();
    xfer(8'h00, 8, got);
    check("r6_restart_miso", {24'd0, got}, 32'h22);
    check("r6_restart_pop", pop_cnt - p0, 32'd1);
    end_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
